// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the register-file write-port
//               controller. Holds the default datapath widths, the buffered
//               writeback entry layout and the hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;

  // Register 0 is hard-wired; writes to it are dropped and never reported as
  // pending to the hazard unit.
  localparam int unsigned REG_ZERO = 0;

  // One buffered long-latency writeback. 'live' is cleared when a younger
  // pipeline write to the same register makes this entry obsolete.
  typedef struct packed {
    logic                     live;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_squash_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_squash_fifo
// Description : Small in-order buffer for long-latency writebacks. Entries can
//               be squashed by destination address (the slot stays occupied
//               but its live bit clears), and two query ports report whether
//               a live buffered write targets a given register.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push          enqueue request (ignored while full)
//   i_push_addr/data  entry contents for the enqueue
//   i_pop           dequeue request (ignored while empty)
//   i_squash_en     clear live bits of resident entries matching i_squash_addr
//   i_query_a/b     hazard query addresses
//   o_ready         buffer not full (registered count only)
//   o_empty         buffer empty
//   o_head_*        contents of the oldest entry
//   o_pending_a/b   a live resident entry targets the query address
// ============================================================================
module wb_squash_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int PTR_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ADDRESS_WIDTH-1:0] i_push_addr,
  input  logic [DATA_WIDTH-1:0]    i_push_data,
  input  logic                     i_pop,
  input  logic                     i_squash_en,
  input  logic [ADDRESS_WIDTH-1:0] i_squash_addr,
  input  logic [ADDRESS_WIDTH-1:0] i_query_a,
  input  logic [ADDRESS_WIDTH-1:0] i_query_b,
  output logic                     o_ready,
  output logic                     o_empty,
  output logic                     o_head_live,
  output logic [ADDRESS_WIDTH-1:0] o_head_addr,
  output logic [DATA_WIDTH-1:0]    o_head_data,
  output logic                     o_pending_a,
  output logic                     o_pending_b
);
  import wb_pkg::*;

  localparam logic [PTR_WIDTH:0]     c_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] c_R0 = ADDRESS_WIDTH'(REG_ZERO);

  logic [ADDRESS_WIDTH-1:0] r_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_valid;
  logic [FIFO_DEPTH-1:0]    r_live;
  logic [PTR_WIDTH-1:0]     r_rd_ptr;
  logic [PTR_WIDTH-1:0]     r_wr_ptr;
  logic [PTR_WIDTH:0]       r_count;

  logic                     w_push;
  logic                     w_pop;
  logic [FIFO_DEPTH-1:0]    w_sq_hit;
  logic [FIFO_DEPTH-1:0]    w_hit_a;
  logic [FIFO_DEPTH-1:0]    w_hit_b;

  assign o_ready = (r_count != c_FULL);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && !o_empty;

  assign o_head_live = r_live[r_rd_ptr];
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Per-entry address compares. Only resident entries take part, so the
  // entry being written this cycle is neither squashed nor reported pending.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    assign w_sq_hit[gi] = i_squash_en && r_valid[gi] && r_live[gi]
                          && (r_addr[gi] == i_squash_addr);
    assign w_hit_a[gi]  = r_valid[gi] && r_live[gi] && (r_addr[gi] == i_query_a);
    assign w_hit_b[gi]  = r_valid[gi] && r_live[gi] && (r_addr[gi] == i_query_b);
  end

  assign o_pending_a = (|w_hit_a) && (i_query_a != c_R0);
  assign o_pending_b = (|w_hit_b) && (i_query_b != c_R0);

  // Control state. The push slot is never resident (not full), and a popped
  // slot is never the push slot, so the later assignments cannot collide
  // with a squash on the same bit in a meaningful way.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_sq_hit[i]) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_live[r_rd_ptr]  <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_live[r_wr_ptr]  <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      r_count <= r_count + (PTR_WIDTH + 1)'(w_push) - (PTR_WIDTH + 1)'(w_pop);
    end
  end

  // Payload storage needs no reset: valid/live gate every use of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

endmodule : wb_squash_fifo
`default_nettype wire

// File: rtl/regfile_write_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_port_ctrl
// Description : Arbitrates the single register-file write port between the
//               in-order WB stage (strict priority, no backpressure) and
//               long-latency units (valid/ready, buffered). Younger pipeline
//               writes squash older buffered writes to the same register.
//               Reports pending buffered writes to the hazard unit.
// Revision    : 1.0 - initial release
//
// Build option: define REGWR_FIFO_BYPASS_EN to let an accepted long transfer
//               go straight to the output registers when the buffer is empty
//               and the WB stage is idle.
//
// Ports:
//   Clk, Reset               clock, synchronous active-high reset
//   WbValid/WbRW/WbData      pipeline writeback request
//   LongValid/LongReady      long-latency handshake
//   LongRW/LongData          long-latency writeback contents
//   RegWr/RW/BusW            registered register-file write port
//   QueryRA/QueryRB          hazard query addresses
//   PendingA/PendingB        live buffered write targets the query address
// ============================================================================
module regfile_write_port_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int PTR_WIDTH     = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     WbValid,
  input  logic [ADDRESS_WIDTH-1:0] WbRW,
  input  logic [DATA_WIDTH-1:0]    WbData,
  input  logic                     LongValid,
  output logic                     LongReady,
  input  logic [ADDRESS_WIDTH-1:0] LongRW,
  input  logic [DATA_WIDTH-1:0]    LongData,
  output logic                     RegWr,
  output logic [ADDRESS_WIDTH-1:0] RW,
  output logic [DATA_WIDTH-1:0]    BusW,
  input  logic [ADDRESS_WIDTH-1:0] QueryRA,
  input  logic [ADDRESS_WIDTH-1:0] QueryRB,
  output logic                     PendingA,
  output logic                     PendingB
);
  import wb_pkg::*;

  localparam logic [ADDRESS_WIDTH-1:0] c_R0 = ADDRESS_WIDTH'(REG_ZERO);

  logic                     r_regwr;
  logic [ADDRESS_WIDTH-1:0] r_rw;
  logic [DATA_WIDTH-1:0]    r_busw;

  logic                     w_wb_write;
  logic                     w_long_xfer;
  logic                     w_long_nz;
  logic                     w_bypass;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_ready;
  logic                     w_fifo_empty;
  logic                     w_head_live;
  logic [ADDRESS_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0]    w_head_data;

  assign w_wb_write  = WbValid && (WbRW != c_R0);
  assign w_long_xfer = LongValid && w_fifo_ready;
  assign w_long_nz   = (LongRW != c_R0);

`ifdef REGWR_FIFO_BYPASS_EN
  // Only legal when nothing older is buffered, so ordering is preserved.
  assign w_bypass = w_long_xfer && w_long_nz && !WbValid && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // R0 transfers complete the handshake but are dropped here.
  assign w_push = w_long_xfer && w_long_nz && !w_bypass;
  // Any WB request, even to R0, owns the port for the cycle.
  assign w_pop  = !WbValid && !w_fifo_empty;

  assign LongReady = w_fifo_ready;

  wb_squash_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .PTR_WIDTH     (PTR_WIDTH)
  ) u_fifo (
    .clk           (Clk),
    .rst           (Reset),
    .i_push        (w_push),
    .i_push_addr   (LongRW),
    .i_push_data   (LongData),
    .i_pop         (w_pop),
    .i_squash_en   (w_wb_write),
    .i_squash_addr (WbRW),
    .i_query_a     (QueryRA),
    .i_query_b     (QueryRB),
    .o_ready       (w_fifo_ready),
    .o_empty       (w_fifo_empty),
    .o_head_live   (w_head_live),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_pending_a   (PendingA),
    .o_pending_b   (PendingB)
  );

  // Output registers: WB stage first, then bypass, then buffered head.
  // A squashed head still consumes its slot and yields an idle write cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_regwr <= 1'b0;
      r_rw    <= '0;
      r_busw  <= '0;
    end else if (WbValid) begin
      r_regwr <= w_wb_write;
      r_rw    <= WbRW;
      r_busw  <= WbData;
    end else if (w_bypass) begin
      r_regwr <= 1'b1;
      r_rw    <= LongRW;
      r_busw  <= LongData;
    end else if (w_pop) begin
      r_regwr <= w_head_live;
      r_rw    <= w_head_addr;
      r_busw  <= w_head_data;
    end else begin
      r_regwr <= 1'b0;
    end
  end

  assign RegWr = r_regwr;
  assign RW    = r_rw;
  assign BusW  = r_busw;

endmodule : regfile_write_port_ctrl
`default_nettype wire

// File: tb/tb_regfile_write_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_port_ctrl
// Description : Self-checking bench for regfile_write_port_ctrl. Directed
//               scenarios plus randomized traffic compared against a
//               queue-based reference model of the write-port rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_port_ctrl;
  import wb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
`ifdef REGWR_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset;
  logic          WbValid;
  logic [AW-1:0] WbRW;
  logic [DW-1:0] WbData;
  logic          LongValid;
  logic          LongReady;
  logic [AW-1:0] LongRW;
  logic [DW-1:0] LongData;
  logic          RegWr;
  logic [AW-1:0] RW;
  logic [DW-1:0] BusW;
  logic [AW-1:0] QueryRA;
  logic [AW-1:0] QueryRB;
  logic          PendingA;
  logic          PendingB;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: buffered writes in age order plus expected port.
  wb_entry_t     mq[$];
  logic          e_regwr;
  logic [AW-1:0] e_rw;
  logic [DW-1:0] e_busw;

  regfile_write_port_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .WbValid(WbValid), .WbRW(WbRW), .WbData(WbData),
    .LongValid(LongValid), .LongReady(LongReady), .LongRW(LongRW),
    .LongData(LongData), .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .QueryRA(QueryRA), .QueryRB(QueryRB), .PendingA(PendingA),
    .PendingB(PendingB)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  function automatic bit m_pending(input logic [AW-1:0] q);
    bit hit = 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == q && q != 0) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit m_ready();
    return mq.size() != DEPTH;
  endfunction

  task automatic idle_inputs();
    Reset = 1'b0; WbValid = 1'b0; WbRW = '0; WbData = '0;
    LongValid = 1'b0; LongRW = '0; LongData = '0;
  endtask

  // Advance the model by one clock using the inputs now applied, then clock
  // the DUT and settle just after the edge.
  task automatic tick();
    wb_entry_t h;
    bit        was_empty, xfer, byp_now;
    if (Reset) begin
      mq.delete();
      e_regwr = 1'b0; e_rw = '0; e_busw = '0;
    end else begin
      was_empty = (mq.size() == 0);
      xfer      = LongValid && (mq.size() != DEPTH);
      byp_now   = BYP && xfer && (LongRW != 0) && !WbValid && was_empty;
      if (WbValid) begin
        e_regwr = (WbRW != 0); e_rw = WbRW; e_busw = WbData;
      end else if (byp_now) begin
        e_regwr = 1'b1; e_rw = LongRW; e_busw = LongData;
      end else if (!was_empty) begin
        h = mq.pop_front();
        e_regwr = h.live; e_rw = h.addr; e_busw = h.data;
      end else begin
        e_regwr = 1'b0;
      end
      if (WbValid && WbRW != 0)
        foreach (mq[i]) if (mq[i].addr == WbRW) mq[i].live = 1'b0;
      if (xfer && LongRW != 0 && !byp_now) begin
        h.live = 1'b1; h.addr = LongRW; h.data = LongData;
        mq.push_back(h);
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); QueryRA = '0; QueryRB = '0;
    Reset = 1'b1; tick(); Reset = 1'b0;
    // Put non-zero values on the port and leave an entry buffered.
    WbValid = 1'b1; WbRW = 5'd7; WbData = 32'hCAFE;
    LongValid = 1'b1; LongRW = 5'd4; LongData = 32'h44;
    tick();
    LongValid = 1'b0;
    Reset = 1'b1; tick(); tick();
    n_tests++;
    if (RegWr !== 1'b0 || RW !== 5'd0 || BusW !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: got RegWr=%b RW=%0d BusW=%h, want 0/0/0", RegWr, RW, BusW);
    end
    n_tests++;
    if (LongReady !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", LongReady);
    end
    idle_inputs();
    tick(); tick();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: got RegWr=%b want 0", RegWr);
    end
  endtask

  task automatic test_wb_priority();
    idle_inputs();
    WbValid = 1'b1; WbRW = 5'd7; WbData = 32'hAA;
    LongValid = 1'b1; LongRW = 5'd3; LongData = 32'h11;
    tick();
    LongValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 32'hAA) begin
      n_fail++; $display("FAIL prio_c1: got %b/%0d/%h want 1/7/aa", RegWr, RW, BusW);
    end
    tick();
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 32'hAA) begin
      n_fail++; $display("FAIL prio_c2: got %b/%0d/%h want 1/7/aa", RegWr, RW, BusW);
    end
    WbValid = 1'b0;
    tick();
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd3 || BusW !== 32'h11) begin
      n_fail++; $display("FAIL prio_drain: got %b/%0d/%h want 1/3/11", RegWr, RW, BusW);
    end
    tick();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle: got RegWr=%b want 0", RegWr);
    end
  endtask

  task automatic test_squash();
    idle_inputs(); QueryRA = 5'd5; QueryRB = 5'd1;
    // Keep the WB stage busy on R1 so the long write is buffered.
    WbValid = 1'b1; WbRW = 5'd1; WbData = 32'h1;
    LongValid = 1'b1; LongRW = 5'd5; LongData = 32'h1234;
    n_tests++;
    if (PendingA !== 1'b0) begin
      n_fail++; $display("FAIL sq_pend_enq: got %b want 0", PendingA);
    end
    tick();
    LongValid = 1'b0;
    n_tests++;
    if (PendingA !== 1'b1) begin
      n_fail++; $display("FAIL sq_pend_live: got %b want 1", PendingA);
    end
    WbRW = 5'd5; WbData = 32'hBEEF;
    tick();
    n_tests++;
    if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 32'hBEEF) begin
      n_fail++; $display("FAIL sq_wb: got %b/%0d/%h want 1/5/beef", RegWr, RW, BusW);
    end
    n_tests++;
    if (PendingA !== 1'b0) begin
      n_fail++; $display("FAIL sq_pend_drop: got %b want 0", PendingA);
    end
    WbValid = 1'b0;
    tick();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL sq_drain: got RegWr=%b want 0", RegWr);
    end
    tick();
  endtask

  task automatic test_full();
    idle_inputs();
    WbValid = 1'b1; WbRW = 5'd2; WbData = 32'h2;
    for (int k = 0; k < 4; k++) begin
      LongValid = 1'b1; LongRW = 5'(10 + k); LongData = 32'hA0 + k;
      n_tests++;
      if (LongReady !== 1'b1) begin
        n_fail++; $display("FAIL full_fill%0d: LongReady got %b want 1", k, LongReady);
      end
      tick();
    end
    LongRW = 5'd14; LongData = 32'hA4;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (LongReady !== 1'b0) begin
        n_fail++; $display("FAIL full_stall%0d: LongReady got %b want 0", k, LongReady);
      end
      tick();
    end
    WbValid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        n_tests++;
        if (LongReady !== 1'b1) begin
          n_fail++; $display("FAIL full_reopen: LongReady got %b want 1", LongReady);
        end
      end
      tick();
      if (k == 1) LongValid = 1'b0;
      n_tests++;
      if (RegWr !== 1'b1 || RW !== 5'(10 + k) || BusW !== 32'hA0 + k) begin
        n_fail++;
        $display("FAIL full_order%0d: got %b/%0d/%h want 1/%0d/%h", k, RegWr, RW, BusW, 10 + k, 32'hA0 + k);
      end
    end
    tick();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: got RegWr=%b want 0", RegWr);
    end
  endtask

  task automatic test_r0();
    idle_inputs(); QueryRA = '0; QueryRB = '0;
    WbValid = 1'b1; WbRW = '0; WbData = 32'hDEAD;
    tick();
    n_tests++;
    if (RegWr !== 1'b0) begin
      n_fail++; $display("FAIL r0_wb: got RegWr=%b want 0", RegWr);
    end
    WbValid = 1'b0;
    LongValid = 1'b1; LongRW = '0; LongData = 32'hBAD;
    n_tests++;
    if (LongReady !== 1'b1) begin
      n_fail++; $display("FAIL r0_ready: got %b want 1", LongReady);
    end
    tick();
    LongValid = 1'b0;
    n_tests++;
    if (RegWr !== 1'b0 || PendingA !== 1'b0) begin
      n_fail++; $display("FAIL r0_long: got RegWr=%b PendingA=%b want 0/0", RegWr, PendingA);
    end
    tick();
    n_tests++;
    if (RegWr !== 1'b0 || LongReady !== 1'b1) begin
      n_fail++; $display("FAIL r0_noenq: got RegWr=%b LongReady=%b want 0/1", RegWr, LongReady);
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    LongValid = 1'b1; LongRW = 5'd9; LongData = 32'h55;
    tick();
    LongValid = 1'b0;
    n_tests++;
    if (RegWr !== BYP) begin
      n_fail++; $display("FAIL byp_c1: got RegWr=%b want %b", RegWr, BYP);
    end
    tick();
    n_tests++;
    if (RegWr !== !BYP) begin
      n_fail++; $display("FAIL byp_c2: got RegWr=%b want %b", RegWr, !BYP);
    end
    n_tests++;
    if (RW !== 5'd9 || BusW !== 32'h55) begin
      n_fail++; $display("FAIL byp_data: got RW=%0d BusW=%h want 9/55", RW, BusW);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      Reset     = ($urandom_range(0, 79) == 0);
      WbValid   = ($urandom_range(0, 9) < 4);
      WbRW      = 5'($urandom_range(0, 7));
      WbData    = $urandom;
      LongValid = ($urandom_range(0, 9) < 6);
      LongRW    = 5'($urandom_range(0, 7));
      LongData  = $urandom;
      QueryRA   = 5'($urandom_range(0, 7));
      QueryRB   = 5'($urandom_range(0, 7));
      #1;
      n_tests++;
      if (LongReady !== m_ready() || PendingA !== m_pending(QueryRA) ||
          PendingB !== m_pending(QueryRB)) begin
        n_fail++;
        $display("FAIL rnd_comb@%0d: got rdy=%b pa=%b pb=%b want %b/%b/%b", c,
                 LongReady, PendingA, PendingB, m_ready(), m_pending(QueryRA), m_pending(QueryRB));
      end
      tick();
      n_tests++;
      if (RegWr !== e_regwr || RW !== e_rw || BusW !== e_busw) begin
        n_fail++;
        $display("FAIL rnd_port@%0d: got %b/%0d/%h want %b/%0d/%h", c,
                 RegWr, RW, BusW, e_regwr, e_rw, e_busw);
      end
    end
  endtask

  initial begin
    idle_inputs();
    QueryRA = '0; QueryRB = '0;
    @(negedge Clk);
    test_reset();
    test_wb_priority();
    test_squash();
    test_full();
    test_r0();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_write_port_ctrl
`default_nettype wire

// File: doc/regfile_write_port_ctrl.md
Name: regfile_write_port_ctrl

Overview:
- Drives the single register-file write port (RegWr/RW/BusW) from two writeback sources.
- Source 1: in-order pipeline WB stage. Strict priority, no backpressure.
- Source 2: long-latency units (mult/div, cache-miss loads). Valid/ready handshake, buffered in a small FIFO, drained when the WB stage is idle.
- Sits between the WB stage / long-latency units and the register file. Also tells the hazard unit which registers have writes still pending.

Parameters:
- DATA_WIDTH, 32, write data width
- ADDRESS_WIDTH, 5, register address width
- FIFO_DEPTH, 4, long-latency buffer entries; must be a power of two, at least 2
- PTR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high reset
- WbValid  input  1  pipeline writeback request this cycle
- WbRW  input  ADDRESS_WIDTH  pipeline destination register
- WbData  input  DATA_WIDTH  pipeline writeback data
- LongValid  input  1  long-latency writeback offered
- LongReady  output  1  buffer can accept; transfer when LongValid && LongReady
- LongRW  input  ADDRESS_WIDTH  long-latency destination register
- LongData  input  DATA_WIDTH  long-latency data
- RegWr  output  1  register-file write enable (registered)
- RW  output  ADDRESS_WIDTH  register-file write address (registered)
- BusW  output  DATA_WIDTH  register-file write data (registered)
- QueryRA  input  ADDRESS_WIDTH  hazard-unit query address A
- QueryRB  input  ADDRESS_WIDTH  hazard-unit query address B
- PendingA  output  1  a live buffered write targets QueryRA
- PendingB  output  1  a live buffered write targets QueryRB

Behaviour:
- Reset (synchronous, checked at posedge Clk):
  - RegWr=0, RW=0, BusW=0.
  - Read/write pointers and count = 0; all entry live bits = 0.
  - LongReady=1 from the first cycle after reset.
  - Reset mid-drain discards all buffered entries with no write issued.
- Output stage, one cycle latency:
  - Cycle N, WbValid=1: at cycle N+1, RegWr=1, RW=WbRW, BusW=WbData.
  - Cycle N, WbValid=0, FIFO non-empty: head is popped. At N+1, RegWr = head live bit, RW/BusW = head contents.
  - Otherwise RegWr=0 at N+1; RW/BusW hold their previous values.
- Register 0:
  - WbValid with WbRW=0 produces RegWr=0.
  - A long transfer with LongRW=0 is accepted (handshake completes) but not enqueued.
- LongReady = (count != FIFO_DEPTH), computed from registered count only.
  - When full, no enqueue happens even if a pop occurs in the same cycle.
  - Enqueue and pop in the same cycle are allowed when not full; count is unchanged.
- Squash, to preserve write ordering:
  - When WbValid with WbRW!=0, every live entry already in the FIFO whose address equals WbRW has its live bit cleared that cycle.
  - Squashed entries still occupy a slot. On pop they produce a cycle with RegWr=0.
  - An entry enqueued in the same cycle as a matching WbValid is NOT squashed; the long write is treated as newer.
- PendingA/B are combinational: OR over entries that are both valid and live of (addr == Query) && (Query != 0).
  - The entry being enqueued this cycle is not included.
- Pointers wrap modulo FIFO_DEPTH; count is PTR_WIDTH+1 bits.

Optional Feature:
- Macro: REGWR_FIFO_BYPASS_EN.
- Defined: when the FIFO is empty and WbValid=0, an accepted long transfer (LongRW!=0) goes straight to the output registers. RegWr=1 next cycle and nothing is enqueued.
- Undefined: every long transfer is enqueued, so the earliest write is two cycles after acceptance.

Decomposition:
- Shared package, wb_pkg:
  - DATA_WIDTH/ADDRESS_WIDTH constants.
  - wb_entry_t struct: live bit, addr, data.
  - REG_ZERO constant.
- One sub-module is natural: wb_squash_fifo, holding storage, pointers, count, the squash-by-address compare and the pending compares.
- The top level keeps the priority mux and the output registers.

Test Plan:
- Reset:
  - Stimulus: hold Reset=1 for 2 cycles with WbValid=1.
  - Required: RegWr=0, RW=0, BusW=0 and LongReady=1 after release.
- WB priority over the FIFO:
  - Stimulus: enqueue R3=0x11; in the same cycle and the next, WbValid R7=0xAA.
  - Required: output cycles give R7=0xAA, then R7 again, then R3=0x11 once WbValid drops.
- Squash:
  - Stimulus: enqueue R5=0x1234; next cycle WbValid R5=0xBEEF; then idle.
  - Required: R5=0xBEEF written; the following drain cycle gives RegWr=0; PendingA (QueryRA=5) drops after the squash.
- Full:
  - Stimulus: enqueue 4 entries while WbValid stays high.
  - Required: LongReady=0; a 5th LongValid stalls; the entries then drain in FIFO order after WbValid drops.
- R0:
  - Stimulus: WbValid with WbRW=0; long transfer with LongRW=0.
  - Required: no RegWr pulse, count unchanged, PendingA=0 for QueryRA=0.
- Bypass, with REGWR_FIFO_BYPASS_EN:
  - Stimulus: empty FIFO, long R9=0x55.
  - Required: RegWr=1, RW=9 on the next cycle (two cycles later without the macro).
